gb_timer_tima: RTL
==================

// Module: gb_timer_tima
// PURPOSE
//  - DMG timer stage downstream of the free-running 16-bit system (DIV) counter.
//  - Consumes the counter value and drives the counter's clear input.
//  - Implements the TIMA/TMA/TAC registers and the overflow-reload sequence.
//  - Raises the timer interrupt request toward the interrupt controller.
// PARAMETERS
//  - OVF_DELAY  4  clk cycles TIMA holds 0x00 after overflow (one M-cycle).
//  - CNT_WID   16  width of the system counter input.
// PORTS
//  clk         in   1         T-cycle clock, 4.194304 MHz
//  reset       in   1         synchronous, active-high
//  sys_cnt     in   CNT_WID   system counter value
//  div_clr     out  1         clear strobe to system counter; comb = cpu_wr && cpu_addr==2'b00
//  cpu_wr      in   1         register write strobe, one clk
//  cpu_addr    in   2         00 DIV(FF04), 01 TIMA(FF05), 10 TMA(FF06), 11 TAC(FF07)
//  cpu_wdata   in   8         write data
//  cpu_rdata   out  8         comb read data; DIV = sys_cnt[15:8], TAC = {5'b11111, tac}
//  irq_timer   out  1         one-clk interrupt request pulse
//  tima_busy   out  1         high while state != RUN
// BEHAVIOUR
//  - Reset: tima=0, tma=0, tac=0, state=RUN, irq_timer=0, edge reg=0, dly cnt=0.
//  - Tap select by tac[1:0]: 00->sys_cnt[9], 01->[3], 10->[5], 11->[7].
//  - Gated tap: tap = tac[2] & selected bit. Registered as tap_q every clk.
//  - Increment: tap_q && !tap (falling edge) increments tima in the same clk.
//  - Overflow: increment with tima==8'hFF -> tima=8'h00, enter DELAY, dly cnt=0.
//  - State RUN: normal operation.
//  - State DELAY: tima reads 00 for OVF_DELAY clks.
//    - A cpu write to TIMA in DELAY loads cpu_wdata, returns to RUN, and cancels both reload and irq.
//    - Falling edges during DELAY are ignored.
//  - DELAY exit: on the last DELAY clk, tima<=tma and irq_timer=1 for one clk; go to RELOAD.
//  - State RELOAD: lasts OVF_DELAY clks, then RUN.
//    - cpu writes to TIMA are ignored.
//    - A cpu write to TMA updates tma AND tima the same clk.
//  - Simultaneous TIMA write and falling edge in RUN: the write wins and the increment is dropped.
//  - TMA/TAC writes take effect the next clk. The tap is recomputed from the new tac.
//  - reset mid-DELAY/RELOAD: immediate return to reset values; no irq.
//  - Width rule: tima wraps modulo 256; only the FF->00 transition triggers overflow.
// CONFIGURATION
//  - Macro GB_TIMER_GLITCH_EN.
//  - Defined: DMG quirks are reproduced.
//    - Writing DIV while the gated tap is 1 yields a falling edge and increments TIMA.
//    - A TAC write that drops the gated tap from 1 to 0 (disable or reselect) increments TIMA.
//  - Undefined: the edge detector is suppressed on any clk with div_clr or a TAC write.
//    - tap_q is reloaded with the new tap value, so no spurious increment occurs.
// STRUCTURE
//  - Package gb_timer_pkg holds:
//    - localparams for register addresses (ADDR_DIV..ADDR_TAC);
//    - typedef enum logic[1:0] {RUN, DELAY, RELOAD} timer_state_t;
//    - function tap_sel(tac, cnt) returning the selected bit.
//  - Sub-module timer_tap_edge: tap mux + gating + falling-edge register.
//    - Inputs: sys_cnt, tac, suppress. Output: inc pulse.
//  - Top holds the register file, the state machine, the delay counter and read mux.
//  - The system counter itself is external, cleared by div_clr.
// TESTING
//  1. Basic count: tac=3'b101, drive sys_cnt incrementing per clk from 0.
//     -> tima increments every 16 clks; reads 0x01 after the first 16.
//  2. Overflow: tma=8'hAB, tima=8'hFF, edge.
//     -> tima=00 for 4 clks, then AB with irq_timer=1 exactly one clk, tima_busy high 8 clks.
//  3. Cancel: write TIMA=8'h10 on clk 2 of DELAY.
//     -> tima=10, no irq, state RUN.
//  4. Reload window: in RELOAD write TIMA=8'h55 then TMA=8'h77.
//     -> TIMA write ignored; tima=77 next clk.
//  5. DIV write glitch: tac=3'b101, sys_cnt[3]=1, cpu_wr DIV.
//     -> div_clr=1 same clk; tima+1 with GLITCH_EN, unchanged without.
//  6. Reset mid-DELAY: assert reset 1 clk in DELAY.
//     -> tima=00, tac=00, irq never pulses, state RUN.

Source files
------------

// File: rtl/gb_timer_pkg.sv
// Shared definitions for the DMG timer: register addresses, the reload state
// encoding and the TAC tap-select helper.
package gb_timer_pkg;

  localparam logic [1:0] ADDR_DIV  = 2'b00;
  localparam logic [1:0] ADDR_TIMA = 2'b01;
  localparam logic [1:0] ADDR_TMA  = 2'b10;
  localparam logic [1:0] ADDR_TAC  = 2'b11;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    RELOAD = 2'd2
  } timer_state_t;

  // Picks the system-counter bit that clocks TIMA for a given TAC rate field.
  function automatic logic tap_sel(input logic [1:0] tac, input logic [9:0] cnt);
    case (tac)
      2'b00:   return cnt[9];
      2'b01:   return cnt[3];
      2'b10:   return cnt[5];
      default: return cnt[7];
    endcase
  endfunction

endpackage

// File: rtl/timer_tap_edge.sv
// Gated tap mux plus falling-edge detector that produces the TIMA increment pulse.
// While i_suppress is high the pulse is masked and the edge register is preloaded
// with the tap value the next clk will see, so a DIV clear or TAC change is silent.
module timer_tap_edge
  import gb_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] i_sys_cnt,
  input  logic [2:0] i_tac,
  input  logic [2:0] i_tac_nxt,
  input  logic       i_cnt_clr,
  input  logic       i_suppress,
  output logic       o_inc
);

  logic w_tap;
  logic w_tap_nxt;
  logic r_tap_q;

  assign w_tap     = i_tac[2] & tap_sel(i_tac[1:0], i_sys_cnt);
  assign w_tap_nxt = i_tac_nxt[2] & tap_sel(i_tac_nxt[1:0], i_cnt_clr ? 10'd0 : i_sys_cnt);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) r_tap_q <= 1'b0;
    else       r_tap_q <= i_suppress ? w_tap_nxt : w_tap;
  end

  assign o_inc = r_tap_q & ~w_tap & ~i_suppress;

endmodule

// File: rtl/gb_timer_tima.sv
// TIMA/TMA/TAC register file with the overflow -> delay -> reload sequence.
// Define GB_TIMER_GLITCH_EN to reproduce the DMG spurious-increment quirks on DIV/TAC writes.
module gb_timer_tima
  import gb_timer_pkg::*;
#(
  parameter int OVF_DELAY = 4,
  parameter int CNT_WID   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_WID-1:0] sys_cnt,
  output logic               div_clr,
  input  logic               cpu_wr,
  input  logic [1:0]         cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               irq_timer,
  output logic               tima_busy
);

  localparam int DLY_W = (OVF_DELAY > 2) ? $clog2(OVF_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(OVF_DELAY - 1);

  timer_state_t     r_state, w_state_nxt;
  logic [7:0]       r_tima, r_tma;
  logic [2:0]       r_tac;
  logic             r_irq;
  logic [DLY_W-1:0] r_dly;

  logic       w_wr_tima, w_wr_tma, w_wr_tac;
  logic [2:0] w_tac_nxt;
  logic       w_suppress, w_inc, w_bump, w_ovf, w_dly_last;

  assign div_clr   = cpu_wr && (cpu_addr == ADDR_DIV);
  assign w_wr_tima = cpu_wr && (cpu_addr == ADDR_TIMA);
  assign w_wr_tma  = cpu_wr && (cpu_addr == ADDR_TMA);
  assign w_wr_tac  = cpu_wr && (cpu_addr == ADDR_TAC);
  assign w_tac_nxt = w_wr_tac ? cpu_wdata[2:0] : r_tac;

`ifdef GB_TIMER_GLITCH_EN
  assign w_suppress = 1'b0;
`else
  assign w_suppress = div_clr | w_wr_tac;
`endif

  timer_tap_edge u_tap_edge (
    .clk        (clk),
    .reset      (reset),
    .i_sys_cnt  (sys_cnt[9:0]),
    .i_tac      (r_tac),
    .i_tac_nxt  (w_tac_nxt),
    .i_cnt_clr  (div_clr),
    .i_suppress (w_suppress),
    .o_inc      (w_inc)
  );

  // Edges count in RUN and RELOAD; a same-clk CPU load of TIMA takes priority.
  assign w_bump     = w_inc && (((r_state == RUN) && !w_wr_tima) ||
                                ((r_state == RELOAD) && !w_wr_tma));
  assign w_ovf      = w_bump && (r_tima == 8'hFF);
  assign w_dly_last = (r_dly == DLY_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // NOTE: the default assignment up front keeps this combinational block latch-free.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:    if (w_ovf) w_state_nxt = DELAY;
      DELAY:  if (w_wr_tima) w_state_nxt = RUN;
              else if (w_dly_last) w_state_nxt = RELOAD;
      RELOAD: if (w_ovf) w_state_nxt = DELAY;
              else if (w_dly_last) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    tima_busy = (r_state != RUN);
    irq_timer = r_irq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tima <= 8'h00;
      r_tma  <= 8'h00;
      r_tac  <= 3'b000;
      r_irq  <= 1'b0;
      r_dly  <= '0;
    end else begin
      r_irq <= 1'b0;
      if (w_wr_tma) r_tma <= cpu_wdata;
      if (w_wr_tac) r_tac <= cpu_wdata[2:0];
      case (r_state)
        RUN: begin
          r_dly <= '0;
          if (w_wr_tima)   r_tima <= cpu_wdata;
          else if (w_bump) r_tima <= r_tima + 8'd1;
        end
        DELAY: begin
          if (w_wr_tima) begin
            r_tima <= cpu_wdata;
          end else if (w_dly_last) begin
            r_tima <= r_tma;
            r_irq  <= 1'b1;
            r_dly  <= '0;
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        RELOAD: begin
          // TMA writes here land in TIMA as well; TIMA writes are dropped.
          if (w_wr_tma)    r_tima <= cpu_wdata;
          else if (w_bump) r_tima <= r_tima + 8'd1;
          if (w_ovf || w_dly_last) r_dly <= '0;
          else                     r_dly <= r_dly + 1'b1;
        end
        default: r_dly <= '0;
      endcase
    end
  end

  always_comb begin
    cpu_rdata = 8'h00;
    case (cpu_addr)
      ADDR_DIV:  cpu_rdata = sys_cnt[15:8];
      ADDR_TIMA: cpu_rdata = r_tima;
      ADDR_TMA:  cpu_rdata = r_tma;
      default:   cpu_rdata = {5'b11111, r_tac};
    endcase
  end

endmodule
